// File: rtl/tx_pkg.sv
// Shared constants for the buffered serial transmitter: parity modes,
// FSM state encoding and frame-length helper.
package tx_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    // Mode 3 is not a legal encoding and is sent without a parity bit.
    function automatic bit has_parity(int unsigned parity_mode);
        return (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    endfunction

    function automatic int unsigned frame_len(int unsigned data_w,
                                              int unsigned parity_mode,
                                              int unsigned stop_bits);
        return 1 + (has_parity(parity_mode) ? 1 : 0) + data_w + stop_bits;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous input FIFO for the transmitter; no pass-through, so a full
// FIFO refuses a push even when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DATA_W     = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head_c,
    output logic                          full_c,
    output logic                          empty_c,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        push_ok_c = push && !full_c;
        pop_ok_c  = pop && !empty_c;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tx_stream.sv
// Buffered one-wire transmitter: FIFO-fed framer sending start, optional
// parity, LSB-first data and stop bits, back-to-back when words are queued.
module tx_stream
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        channel_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam bit          USE_PAR = has_parity(PARITY_MODE);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               channel_out_q, channel_out_d;
    logic               busy_q, busy_d;

    logic               tick_c;
    logic               fifo_pop_c;
    logic               fifo_push_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    logic [DATA_W-1:0]  fifo_head_c;

    assign in_ready    = !fifo_full_c;
    assign fifo_push_c = in_valid && in_ready;
    assign channel_out = channel_out_q;
    assign busy        = busy_q;

    tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_c),
        .push_data (in_data),
        .pop       (fifo_pop_c),
        .head_c    (fifo_head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .count     (fifo_count)
    );

    assign tick_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state, counters and shift register; every state entry coincides
    // with a bit-period wrap, so the counter restarts from zero on entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick_c ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        fifo_pop_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty_c) begin
                    fifo_pop_c = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    idx_d   = '0;
                    state_d = USE_PAR ? ST_PARITY : ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        if (!fifo_empty_c) begin
                            fifo_pop_c = 1'b1;
                            state_d    = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Frame content is captured at pop and never touched by later pushes.
        if (fifo_pop_c) begin
            shreg_d = fifo_head_c;
            par_d   = (PARITY_MODE == PAR_ODD) ? ~^fifo_head_c : ^fifo_head_c;
        end

        case (state_d)
            ST_START:  channel_out_d = 1'b1;
            ST_PARITY: channel_out_d = par_d;
            ST_DATA:   channel_out_d = shreg_d[0];
            ST_STOP:   channel_out_d = 1'b1;
            default:   channel_out_d = 1'b0;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            channel_out_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            channel_out_q <= channel_out_d;
            busy_q        <= busy_d;
        end
    end

endmodule
